// File: rtl/key_debounce_evt_if.sv
// Key bundle between board pins, the debouncer and its consumers.
// Latency: none, wires only.
// Backpressure: none; event pulses are fire-and-forget.
interface key_debounce_evt_if;
    logic [3:0] key;          // raw keys, active-low, asynchronous
    logic [3:0] key_value;    // debounced levels, active-low
    logic [3:0] key_press;    // one-cycle pulse on debounced 1->0
    logic [3:0] key_release;  // one-cycle pulse on debounced 0->1
    logic [3:0] key_long;     // one-cycle pulse of keys held at long-press timeout

    // Debouncer side: consumes raw keys, produces clean levels and events
    modport master (
        input  key,
        output key_value,
        output key_press,
        output key_release,
        output key_long
    );

    // Board/consumer side: drives raw keys, observes levels and events
    modport slave (
        output key,
        input  key_value,
        input  key_press,
        input  key_release,
        input  key_long
    );
endinterface

// File: rtl/key_debounce_evt.sv
// Debounces four raw active-low keys and emits press/release/long-press pulses.
// Latency: key_value follows a stable raw change DEBOUNCE_CNT+2 cycles after first sample; pulses one cycle later.
// Backpressure: none; consumers must take each single-cycle pulse when it appears.
module key_debounce_evt #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int LONG_CNT     = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_debounce_evt_if.master kif
);

    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam int LW = $clog2(LONG_CNT);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CNT - 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_CNT - 1);
    localparam logic [3:0]    ALL_UP = 4'b1111;

    typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;

    logic [3:0]    key_s1_q, key_s1_d;
    logic [3:0]    key_s_q, key_s_d;
    logic [3:0]    key_d_q, key_d_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    key_value_q, key_value_d;
    logic [3:0]    kv_d_q, kv_d_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    release_q, release_d;
    logic [3:0]    long_q, long_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    state_t        state_q, state_d;

    // Synchroniser, debounce counter and edge detection on the debounced level.
    // A single counter covers all four keys, so bounce on any key holds all of them back.
    always_comb begin
        key_s1_d    = kif.key;
        key_s_d     = key_s1_q;
        key_d_d     = key_s_q;
        dcnt_d      = dcnt_q;
        key_value_d = key_value_q;
        if (key_s_q != key_d_q) begin
            dcnt_d = '0;
        end else begin
            if (dcnt_q != DMAX) begin
                dcnt_d = dcnt_q + 1'b1;
            end else begin
                key_value_d = key_s_q;
            end
        end
        kv_d_d    = key_value_q;
        press_d   = kv_d_q & ~key_value_q;
        release_d = ~kv_d_q & key_value_q;
    end

    // Long-press timing: one pulse per unchanged held combination, restarted by any change.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        long_d  = '0;
        case (state_q)
            IDLE: begin
                lcnt_d = '0;
                if (key_value_q != ALL_UP) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (key_value_q != kv_d_q) begin
                    lcnt_d = '0;
                    if (key_value_q == ALL_UP) begin
                        state_d = IDLE;
                    end
                end else if (lcnt_q == LMAX) begin
                    long_d  = ~key_value_q;
                    state_d = LONG;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            LONG: begin
                if (key_value_q != kv_d_q) begin
                    lcnt_d  = '0;
                    state_d = (key_value_q == ALL_UP) ? IDLE : HOLD;
                end
            end
            default: begin
                lcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset forces released keys and silences all pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            key_s1_q    <= ALL_UP;
            key_s_q     <= ALL_UP;
            key_d_q     <= ALL_UP;
            dcnt_q      <= '0;
            key_value_q <= ALL_UP;
            kv_d_q      <= ALL_UP;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            lcnt_q      <= '0;
            state_q     <= IDLE;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s_q     <= key_s_d;
            key_d_q     <= key_d_d;
            dcnt_q      <= dcnt_d;
            key_value_q <= key_value_d;
            kv_d_q      <= kv_d_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            lcnt_q      <= lcnt_d;
            state_q     <= state_d;
        end
    end

    assign kif.key_value   = key_value_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;

endmodule
